instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding instruction decode and the control unit. Holds the PC, issues one
//  32-bit fetch at a time to instruction memory via valid/ready, and buffers returned
//  instructions in a small FIFO. Presents instr/pc/opcode to decode with valid/ready.
//  Executes taken-branch redirects: flushes the FIFO and discards any in-flight response.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH  2              instruction buffer entries; power of 2, >= 2
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_addr    out  32  fetch address, word aligned
//  imem_req_ready   in   1   memory accepts request
//  imem_resp_valid  in   1   response valid; >=1 cycle after acceptance; at most 1 outstanding
//  imem_resp_data   in   32  fetched instruction word
//  redirect_valid   in   1   taken branch/jump from execute
//  redirect_pc      in   32  redirect target; bits [1:0] forced to 0
//  if_valid         out  1   FIFO head valid
//  if_ready         in   1   decode accepts head
//  if_instr         out  32  head instruction; 32'h0 when empty
//  if_pc            out  32  head PC; 32'h0 when empty
//  if_opcode        out  7   if_instr[6:0], feeds control unit opcode input
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_REQ, FIFO empty, counters 0; all outputs 0 during rst.
//  FSM (3 states):
//   S_REQ : imem_req_valid = (fifo_count < FIFO_DEPTH) && !redirect_valid; addr = pc.
//           valid&&ready -> S_WAIT. valid held stable with addr until accepted.
//   S_WAIT: resp_valid && !redirect_valid -> push {pc,data}, pc<=pc+4, -> S_REQ.
//           redirect_valid && resp_valid -> drop resp, -> S_REQ.
//           redirect_valid && !resp_valid -> -> S_DROP.
//   S_DROP: resp_valid -> discard, -> S_REQ. Further redirects update pc, stay S_DROP.
//  Redirect (any state): pc<=redirect_pc&~3, FIFO flushed (count=0) same edge; flush beats
//   a concurrent pop or push. if_valid=0 the cycle after redirect.
//  Credit: request only in S_REQ with count<FIFO_DEPTH; FIFO can never overflow, and a pop
//   concurrent with push is legal at any occupancy.
//  FIFO: registered; pushed entry visible on if_valid the cycle after push. Pop on
//   if_valid&&if_ready. Circular pointers wrap at FIFO_DEPTH; no fall-through.
//  Latency: req accepted cycle N, resp at N+1 -> if_valid at N+2. Back-to-back sustains
//   one instruction per 2 cycles.
//  Arithmetic: pc+4 mod 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
//  Reset mid-operation: outstanding response ignored (state forced to S_REQ); memory
//   must drop requests on rst.
//  if_opcode always equals if_instr[6:0] (0 when empty).
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs fetch_count[31:0] (instructions popped by decode)
//   and flush_count[31:0] (redirect_valid cycles); both reset to 0, wrap mod 2^32.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  T1 reset: rst 2 cycles, then release; imem_req_valid=1, addr=RESET_PC, if_valid=0.
//  T2 stream: ready=1, resp 1 cycle later with 0x00500093,0x00A00113,... -> if_pc
//     0,4,8 in order, if_opcode=0x13, one instr every 2 cycles.
//  T3 backpressure: if_ready=0 -> after 2 pushes req_valid=0, count=2; if_ready=1 ->
//     fetching resumes at PC 8, no loss/duplication.
//  T4 redirect in S_WAIT: redirect_pc=0x100, resp arrives 3 cycles later -> response
//     dropped, next req addr=0x100, FIFO empty after redirect.
//  T5 redirect+resp same cycle and redirect_pc=0x203: resp dropped, next addr=0x200.
//  T6 wrap: RESET_PC=0xFFFFFFFC -> second request addr=0x00000000; with
//     IFU_PERF_CNT_EN, fetch_count=2 after two pops.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Fetch stage in front of decode and the control unit. It holds the PC and
//   issues one word-aligned 32-bit fetch at a time to instruction memory over a
//   valid/ready request channel. At most one request is outstanding. Returned
//   words are buffered with their PC in a small registered FIFO and presented
//   to decode over a valid/ready interface. A taken-branch redirect from
//   execute reloads the PC, flushes the FIFO and discards any in-flight
//   response.
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports:
//   clk, rst                   single rising-edge clock, synchronous active-high reset
//   imem_req_valid/_addr/_ready  fetch request channel to instruction memory
//   imem_resp_valid/_data      fetch response (>= 1 cycle after acceptance)
//   redirect_valid/_pc         taken branch/jump target (bits [1:0] ignored)
//   if_valid/_ready            decode handshake on the FIFO head
//   if_instr/_pc/_opcode       head instruction, its PC and opcode (0 when empty)
//
// Configuration:
//   IFU_PERF_CNT_EN  when defined, adds fetch_count (instructions popped by
//                    decode) and flush_count (redirect cycles); both wrap mod 2^32.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fifo_instr_q [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q    [FIFO_DEPTH];

    logic               req_fire;
    logic               push;
    logic               pop;

    // Requests are only offered with a free FIFO slot (credit), so a push can
    // never overflow; a redirect suppresses the request for that cycle since
    // the address is about to change.
    assign imem_req_valid = !rst && (state_q == S_REQ) &&
                            (count_q < CNT_W'(FIFO_DEPTH)) && !redirect_valid;
    assign imem_req_addr  = rst ? 32'h0 : pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid  = !rst && (count_q != '0);
    assign if_instr  = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    assign if_opcode = if_instr[6:0];
    assign pop       = if_valid && if_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                    // A response coinciding with a redirect belongs to the
                    // wrong path and is dropped.
                    if (!redirect_valid) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    // Response still owed by memory; swallow it in S_DROP.
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) pc_d = redirect_pc & ~32'h3;
    end

    // Flush wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer storage carries data only; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_resp_data;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // A pop in a redirect cycle is squashed by the flush, so it is not counted.
    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (pop && !redirect_valid) fetch_count_d = fetch_count_q + 32'd1;
        if (redirect_valid)         flush_count_d = flush_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'h0;
            flush_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = rst ? 32'h0 : fetch_count_q;
    assign flush_count = rst ? 32'h0 : flush_count_q;
`endif

endmodule
